// File: rtl/rca_word_sequencer.sv
// Multi-precision add controller: walks a WORDS x 16-bit operand pair through an
// external 16-bit ripple-carry adder, LSB slice first, chaining the carry between slices.
module rca_word_sequencer #(
  parameter int WORDS  = 4,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   in_a,
  input  logic [16*WORDS-1:0]   in_b,
  input  logic                  in_cin,
  output logic [15:0]           rca_a,
  output logic [15:0]           rca_b,
  output logic                  rca_cin,
  input  logic [15:0]           rca_sum,
  input  logic                  rca_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   result,
  output logic                  cout,
  output logic                  ovf,
  output logic [1:0]            dbg_state
);

  localparam int W     = 16 * WORDS;
  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;

  // Handshakes: a transfer happens on a posedge where valid && ready are both high.
  // in_ready is high only in IDLE, out_valid only in DONE; neither depends on the
  // opposite side's signal, so there is no combinational path between the two ports.
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign dbg_state = state;

  // Adder inputs come straight from operand/carry registers, gated to zero outside RUN.
  assign rca_a   = (state == S_RUN) ? a_reg[16*idx +: 16] : 16'h0000;
  assign rca_b   = (state == S_RUN) ? b_reg[16*idx +: 16] : 16'h0000;
  assign rca_cin = (state == S_RUN) ? carry : 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_b;
            carry <= in_cin;
            idx   <= '0;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (cnt == CNT_LAST) begin
            result[16*idx +: 16] <= rca_sum;
            carry <= rca_cout;
            idx   <= idx + 1'b1;
            cnt   <= '0;
            if (idx == IDX_LAST) begin
              // Signed overflow: like-signed operands producing an opposite-signed sum.
              cout  <= rca_cout;
              ovf   <= (a_reg[W-1] == b_reg[W-1]) && (rca_sum[15] != a_reg[W-1]);
              state <= S_DONE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_word_sequencer.sv
// Bench for rca_word_sequencer: behavioural adder on the rca_* side, plain-arithmetic
// reference model with an expected queue, default instance plus a WORDS=2/SETTLE=3 instance.
module tb_rca_word_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Default instance (WORDS=4, SETTLE=1)
  logic        in_valid, in_ready, in_cin, out_valid, out_ready, cout, ovf;
  logic [63:0] in_a, in_b, result;
  logic [15:0] rca_a, rca_b, rca_sum;
  logic        rca_cin, rca_cout;
  logic [1:0]  dbg_state;

  // Second instance (WORDS=2, SETTLE=3)
  logic        in_valid2, in_ready2, in_cin2, out_valid2, out_ready2, cout2, ovf2;
  logic [31:0] in_a2, in_b2, result2;
  logic [15:0] rca_a2, rca_b2, rca_sum2;
  logic        rca_cin2, rca_cout2;
  logic [1:0]  dbg_state2;

  assign {rca_cout, rca_sum}   = {1'b0, rca_a} + {1'b0, rca_b} + 17'(rca_cin);
  assign {rca_cout2, rca_sum2} = {1'b0, rca_a2} + {1'b0, rca_b2} + 17'(rca_cin2);

  rca_word_sequencer #(.WORDS(4), .SETTLE(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .rca_a(rca_a), .rca_b(rca_b), .rca_cin(rca_cin),
    .rca_sum(rca_sum), .rca_cout(rca_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf),
    .dbg_state(dbg_state)
  );

  rca_word_sequencer #(.WORDS(2), .SETTLE(3)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a2), .in_b(in_b2), .in_cin(in_cin2),
    .rca_a(rca_a2), .rca_b(rca_b2), .rca_cin(rca_cin2),
    .rca_sum(rca_sum2), .rca_cout(rca_cout2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .result(result2), .cout(cout2), .ovf(ovf2),
    .dbg_state(dbg_state2)
  );

  int checks = 0;
  int errors = 0;
  logic [65:0] exp_q[$];  // {ovf, cout, result}

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Carry into slice k: carry out of the sum of the k low slices plus cin.
  function automatic logic carry_in(input logic [63:0] a, input logic [63:0] b,
                                    input logic cin, input int k);
    logic [64:0] mask;
    logic [64:0] s;
    mask = (65'd1 << (16 * k)) - 65'd1;
    s = ({1'b0, a} & mask) + ({1'b0, b} & mask) + 65'(cin);
    return s[16 * k];
  endfunction

  task automatic check_reset_state();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_rca", {rca_a, rca_b, rca_cin}, 0);
    check("rst_in_ready2", in_ready2, 1);
    check("rst_out_valid2", out_valid2, 0);
    check("rst_result2", result2, 0);
  endtask

  // One full operation on the default instance; hold = cycles of out_ready low in DONE.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                        input int hold);
    logic [64:0] s;
    logic        e_ovf;
    logic [65:0] exp;
    s = {1'b0, a} + {1'b0, b} + 65'(cin);
    e_ovf = (a[63] == b[63]) && (s[63] != a[63]);
    exp_q.push_back({e_ovf, s[64], s[63:0]});
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    check("in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_cin = 1'($urandom_range(0, 1));
    for (int c = 0; c < 4; c++) begin
      check("rca_a", rca_a, a[16*c +: 16]);
      check("rca_b", rca_b, b[16*c +: 16]);
      check("rca_cin", rca_cin, carry_in(a, b, cin, c));
      check("in_ready_run", in_ready, 0);
      check("out_valid_run", out_valid, 0);
      @(negedge clk);
    end
    check("out_valid_latency", out_valid, 1);
    for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL out_valid_timeout: got 0 expected 1 (state %0d)", dbg_state);
    end
    exp = exp_q.pop_front();
    check("result", result, exp[63:0]);
    check("cout", cout, exp[64]);
    check("ovf", ovf, exp[65]);
    check("rca_idle_done", {rca_a, rca_b, rca_cin}, 0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_outputs", {ovf, cout, result}, exp);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_out_valid", out_valid, 0);
    check("post_hs_kept", {ovf, cout, result}, exp);
  endtask

  // One operation on the WORDS=2, SETTLE=3 instance.
  task automatic run_op2(input logic [31:0] a, input logic [31:0] b, input logic cin);
    logic [32:0] s;
    logic        e_ovf;
    int          k;
    s = {1'b0, a} + {1'b0, b} + 33'(cin);
    e_ovf = (a[31] == b[31]) && (s[31] != a[31]);
    in_a2 = a; in_b2 = b; in_cin2 = cin; in_valid2 = 1'b1;
    check("w2_in_ready", in_ready2, 1);
    @(negedge clk);
    in_valid2 = 1'b0;
    in_a2 = $urandom; in_b2 = $urandom;
    for (int c = 0; c < 6; c++) begin
      k = c / 3;
      check("w2_rca_a", rca_a2, a[16*k +: 16]);
      check("w2_rca_b", rca_b2, b[16*k +: 16]);
      check("w2_rca_cin", rca_cin2, carry_in({32'h0, a}, {32'h0, b}, cin, k));
      check("w2_out_valid_run", out_valid2, 0);
      @(negedge clk);
    end
    check("w2_out_valid_latency", out_valid2, 1);
    for (int t = 0; t < 20 && !out_valid2; t++) @(negedge clk);
    if (!out_valid2) begin
      checks++; errors++;
      $display("FAIL w2_out_valid_timeout: got 0 expected 1 (state %0d)", dbg_state2);
    end
    check("w2_result", result2, s[31:0]);
    check("w2_cout", cout2, s[32]);
    check("w2_ovf", ovf2, e_ovf);
    out_ready2 = 1'b1;
    @(negedge clk);
    out_ready2 = 1'b0;
    check("w2_post_hs_in_ready", in_ready2, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 0; in_a = 0; in_b = 0; in_cin = 0; out_ready = 0;
    in_valid2 = 0; in_a2 = 0; in_b2 = 0; in_cin2 = 0; out_ready2 = 0;

    // Reset held with random input activity
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
      in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
      @(negedge clk);
      check_reset_state();
    end
    in_valid = 0; out_ready = 0;
    rst = 1'b1;

    // Directed cases
    run_op(64'h0, 64'h1, 1'b0, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 0);
    run_op(64'hAAAA_AAAA_AAAA_AAAB, 64'h5555_5555_5555_5555, 1'b1, 0);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0);
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 5);
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 0);

    // Reset asserted mid-RUN aborts the operation
    in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_state();
    @(negedge clk);
    check_reset_state();
    rst = 1'b1;

    // Randomized operations with random backpressure
    for (int i = 0; i < 25; i++) begin
      run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
             $urandom_range(0, 3));
    end

    // WORDS=2, SETTLE=3 instance
    run_op2(32'h0001_FFFF, 32'h0000_0001, 1'b0);
    run_op2(32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      run_op2($urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rca_word_sequencer.md
# rca_word_sequencer

Multi-precision add controller wrapped around the team's 16-bit ripple-carry adder (`RCA_16bit`). It accepts a WORDS×16-bit operand pair over a valid/ready handshake and feeds the adder one 16-bit slice at a time, LSB slice first. It captures each slice's sum and carry-out, chains that carry into the next slice, and presents the full-width result with carry-out and signed overflow over a second valid/ready handshake. It drives the adder's inputs and consumes the adder's outputs, so it sits on both sides of the existing adder stage.

## Interface
- `WORDS`, 4: number of 16-bit slices; operand/result width W = 16*WORDS; legal ≥ 2.
- `SETTLE`, 1: cycles each slice is held on the adder before its sum is captured; legal ≥ 1.

- `clk` in 1: clock; all state changes on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair present.
- `in_ready` out 1: block can accept operands.
- `in_a` in W: operand A.
- `in_b` in W: operand B.
- `in_cin` in 1: carry into slice 0.
- `rca_a` out 16: slice of A to adder.
- `rca_b` out 16: slice of B to adder.
- `rca_cin` out 1: carry to adder.
- `rca_sum` in 16: adder sum.
- `rca_cout` in 1: adder carry-out.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes result.
- `result` out W: A + B + cin, modulo 2^W.
- `cout` out 1: carry out of slice WORDS-1.
- `ovf` out 1: two's-complement overflow.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready` at a posedge: register `in_a`, `in_b`; set the carry register to `in_cin`; clear slice index `idx` and settle counter `cnt`; go to RUN.
- RUN:
  - `rca_a`=A_reg[16*idx +: 16], `rca_b`=B_reg[16*idx +: 16], `rca_cin`=carry register. All three are driven from registers; no input port reaches them combinationally.
  - Each posedge with `cnt`==SETTLE-1 is a capture: `result[16*idx +: 16]` ← `rca_sum`, carry register ← `rca_cout`, `idx`++, `cnt`←0. Otherwise `cnt`++.
  - The capture at `idx`==WORDS-1 also loads `cout` ← `rca_cout` and `ovf` ← (A_reg[W-1]==B_reg[W-1]) && (`rca_sum`[15]!=A_reg[W-1]), then goes to DONE.
- DONE:
  - `out_valid`=1; `result`, `cout`, `ovf` held stable.
  - On `out_valid`&&`out_ready`: go to IDLE. `result`, `cout` and `ovf` keep their values until the next operation overwrites them.
- Outside RUN, `rca_a`, `rca_b` and `rca_cin` are driven to 0.
- `in_valid` is ignored outside IDLE, and `in_a`, `in_b`, `in_cin` may change freely during RUN and DONE. `out_ready` is ignored outside DONE.
- Width rules:
  - `idx` is ceil(log2(WORDS)) bits; `cnt` is max(1, ceil(log2(SETTLE))) bits.
  - Addition is unsigned modulo 2^W; `cout` is the unsigned carry and `ovf` is the signed overflow, both valid only while `out_valid`=1.

## Timing
- Reset (`rst`=0) forces, asynchronously: state IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `cout`=0, `ovf`=0, `rca_*`=0, `idx`=0, `cnt`=0, carry register 0.
- Reset asserted mid-RUN or mid-DONE aborts the operation and discards partial results. The first posedge after release may accept.
- Latency:
  - `out_valid` rises WORDS*SETTLE posedges after the accepting posedge; default 4 cycles.
  - Slice k is on `rca_*` during cycles k*SETTLE+1 … (k+1)*SETTLE after acceptance.
- `in_ready` is combinational from state: 0 in RUN and DONE.
- After the DONE handshake, `in_ready` is 1 in the following cycle. There is no same-cycle accept; throughput is one operation per WORDS*SETTLE+2 cycles with `out_ready` tied high.
- `out_valid` never drops without a handshake or a reset.

## Test plan
- Reset: hold `rst`=0 with random inputs → `in_ready`=1, `out_valid`=0, `result`=0, `cout`=0, `ovf`=0, `rca_*`=0; asserting reset mid-RUN returns the block to this same state.
- Basic (WORDS=4, SETTLE=1): A=0, B=1, cin=0 → `result`=64'h1, `cout`=0, `ovf`=0, `out_valid` exactly 4 cycles after accept; `rca_a` per slice = 0,0,0,0 and `rca_b` = 1,0,0,0.
- Full carry chain: A=64'hFFFF_FFFF_FFFF_FFFF, B=0, cin=1 → `rca_cin`=1 in every slice, `result`=0, `cout`=1, `ovf`=0. Also A=64'hAAAA_AAAA_AAAA_AAAB, B=64'h5555_5555_5555_5555, cin=1 → `result`=64'h1, `cout`=1.
- Signed overflow: A=64'h7FFF_FFFF_FFFF_FFFF, B=1, cin=0 → `result`=64'h8000_0000_0000_0000, `cout`=0, `ovf`=1. Also A=B=64'h8000_0000_0000_0000 → `result`=0, `cout`=1, `ovf`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE while pulsing `in_valid` with new operands → outputs stable, `in_ready`=0, new operands not taken; after the handshake, `in_ready`=1 next cycle and the next operand pair computes correctly.
- SETTLE=3, WORDS=2: A=32'h0001_FFFF, B=32'h0000_0001 → each slice held 3 cycles, `out_valid` after 6 cycles, `result`=32'h0002_0000, `cout`=0.
